// File: rtl/range_stream_source.sv
// Buffered sample-stream source for a range-finding consumer: plays buffered
// samples out on go/data_out, waits for finish, and self-checks the reported range.
module range_stream_source #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         go,
  output logic [WIDTH-1:0]             data_out,
  input  logic                         finish,
  input  logic [WIDTH-1:0]             range_in,
  output logic                         done,
  output logic [WIDTH-1:0]             range_out,
  output logic                         mismatch,
  output logic                         timeout,
  output logic                         overflow
);

  // state    | meaning
  // S_IDLE   | accept host writes, wait for start
  // S_STREAM | drive buffered samples with go high
  // S_WAIT   | wait for finish or timeout
  // S_DONE   | one-cycle done pulse, buffer emptied
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  logic [WIDTH-1:0] sample_mem [DEPTH];
  logic [CW-1:0]    rd;
  logic [TW-1:0]    wait_cnt;
  logic [WIDTH-1:0] run_min;
  logic [WIDTH-1:0] run_max;
  logic             full;
  logic             wr_accept;
  logic             start_accept;

  assign full         = (count == CW'(DEPTH));
  assign wr_accept    = (state == S_IDLE) && wr_en && !full;
  // A write in the same cycle as start counts, so an empty buffer can still launch.
  assign start_accept = (state == S_IDLE) && start && ((count != '0) || wr_accept);

  always_ff @(posedge clock) begin
    if (wr_accept) sample_mem[count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      go        <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_out <= '0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      rd        <= '0;
      wait_cnt  <= '0;
      run_min   <= '1;
      run_max   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            if (!full) begin
              count <= count + CW'(1);
              if (wr_data < run_min) run_min <= wr_data;
              if (wr_data > run_max) run_max <= wr_data;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (start_accept) begin
            state    <= S_STREAM;
            busy     <= 1'b1;
            go       <= 1'b1;
            data_out <= (count == '0) ? wr_data : sample_mem[0];
            rd       <= CW'(1);
            overflow <= 1'b0;
          end
        end
        S_STREAM: begin
          if (rd == count) begin
            go       <= 1'b0;
            data_out <= '0;
            wait_cnt <= TW'(TIMEOUT - 1);
            state    <= S_WAIT;
          end else begin
            data_out <= sample_mem[rd[AW-1:0]];
            rd       <= rd + CW'(1);
          end
        end
        S_WAIT: begin
          if (finish) begin
            range_out <= range_in;
            mismatch  <= (range_in != (run_max - run_min));
            timeout   <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (wait_cnt == '0) begin
            range_out <= '0;
            mismatch  <= 1'b1;
            timeout   <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          count   <= '0;
          rd      <= '0;
          run_min <= '1;
          run_max <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
